// File: rtl/regs_wr_arbiter.sv
// ---------------------------------------------------------------------------
// regs_wr_arbiter
//   Merges two register-file writeback streams (0 = ALU, 1 = load) into the
//   single register-file write port. Each requester owns a one-entry buffer.
//   A round-robin pointer arbitrates when both buffers are full. The winning
//   entry is registered onto regWrite/writeReg/writeData. Writes to x0 are
//   consumed silently. A hazard flag tells decode that a read index still
//   has a write in flight inside this block.
//
// Ports
//   clock, reset                : clock; asynchronous active-low reset
//   reqN_valid/ready/addr/data  : valid/ready write request from requester N
//   regWrite/writeReg/writeData : registered register-file write port
//   readReg1/readReg2           : decode-stage read indices
//   hazard1/hazard2             : read index matches a pending write
//   commit_count                : number of non-x0 commits, modulo 2^16
// ---------------------------------------------------------------------------
module regs_wr_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              regWrite,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  output logic              hazard1,
  output logic              hazard2,
  output logic [15:0]       commit_count
);

  // Request buffers
  logic              buf0_vld_q, buf0_vld_d;
  logic [ADDR_W-1:0] buf0_addr_q;
  logic [DATA_W-1:0] buf0_data_q;
  logic              buf1_vld_q, buf1_vld_d;
  logic [ADDR_W-1:0] buf1_addr_q;
  logic [DATA_W-1:0] buf1_data_q;

  // Arbitration state: 0 favours requester 0 on the next contest
  logic              ptr_q, ptr_d;

  // Output stage
  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] writereg_q, writereg_d;
  logic [DATA_W-1:0] writedata_q, writedata_d;
  logic [15:0]       cnt_q, cnt_d;

  logic              gnt0, gnt1, commit, load0, load1;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;

  // Grant and handshake
  always_comb begin
    gnt0     = buf0_vld_q && (!buf1_vld_q || !ptr_q);
    gnt1     = buf1_vld_q && (!buf0_vld_q ||  ptr_q);
    gnt_addr = gnt1 ? buf1_addr_q : buf0_addr_q;
    gnt_data = gnt1 ? buf1_data_q : buf0_data_q;
    // A granted x0 write still drains its buffer but never reaches the port.
    commit   = (gnt0 || gnt1) && (gnt_addr != '0);
    // A buffer being drained this cycle can be refilled on the same edge.
    req0_ready = !buf0_vld_q || gnt0;
    req1_ready = !buf1_vld_q || gnt1;
    load0      = req0_valid && req0_ready;
    load1      = req1_valid && req1_ready;
  end

  // Next state
  always_comb begin
    buf0_vld_d  = buf0_vld_q;
    buf1_vld_d  = buf1_vld_q;
    ptr_d       = ptr_q;
    regwrite_d  = commit;
    writereg_d  = writereg_q;
    writedata_d = writedata_q;
    cnt_d       = cnt_q;

    if (load0)     buf0_vld_d = 1'b1;
    else if (gnt0) buf0_vld_d = 1'b0;
    if (load1)     buf1_vld_d = 1'b1;
    else if (gnt1) buf1_vld_d = 1'b0;

    // After a contest the loser becomes the favoured side.
    if (buf0_vld_q && buf1_vld_q) ptr_d = gnt0;

    if (commit) begin
      writereg_d  = gnt_addr;
      writedata_d = gnt_data;
      cnt_d       = cnt_q + 16'd1;
    end
  end

  // Control and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      buf0_vld_q  <= 1'b0;
      buf1_vld_q  <= 1'b0;
      ptr_q       <= 1'b0;
      regwrite_q  <= 1'b0;
      writereg_q  <= '0;
      writedata_q <= '0;
      cnt_q       <= '0;
    end else begin
      buf0_vld_q  <= buf0_vld_d;
      buf1_vld_q  <= buf1_vld_d;
      ptr_q       <= ptr_d;
      regwrite_q  <= regwrite_d;
      writereg_q  <= writereg_d;
      writedata_q <= writedata_d;
      cnt_q       <= cnt_d;
    end
  end

  // Buffer payload; qualified by the valid bits, so it needs no reset
  always_ff @(posedge clock) begin
    if (load0) begin
      buf0_addr_q <= req0_addr;
      buf0_data_q <= req0_data;
    end
    if (load1) begin
      buf1_addr_q <= req1_addr;
      buf1_data_q <= req1_data;
    end
  end

  // Hazard detection against both buffers and the write port
  always_comb begin
    hazard1 = (readReg1 != '0) &&
              ((buf0_vld_q && (buf0_addr_q == readReg1)) ||
               (buf1_vld_q && (buf1_addr_q == readReg1)) ||
               (regwrite_q && (writereg_q  == readReg1)));
    hazard2 = (readReg2 != '0) &&
              ((buf0_vld_q && (buf0_addr_q == readReg2)) ||
               (buf1_vld_q && (buf1_addr_q == readReg2)) ||
               (regwrite_q && (writereg_q  == readReg2)));
  end

  assign regWrite     = regwrite_q;
  assign writeReg     = writereg_q;
  assign writeData    = writedata_q;
  assign commit_count = cnt_q;

endmodule

// File: tb/tb_regs_wr_arbiter.sv
module tb_regs_wr_arbiter;
  localparam int DW      = 32;
  localparam int AW      = 5;
  localparam int NSTREAM = 70000;

  logic          clock;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_data, req1_data;
  logic          regWrite;
  logic [AW-1:0] writeReg;
  logic [DW-1:0] writeData;
  logic [AW-1:0] readReg1, readReg2;
  logic          hazard1, hazard2;
  logic [15:0]   commit_count;

  regs_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_addr(req1_addr), .req1_data(req1_data),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .readReg1(readReg1), .readReg2(readReg2),
    .hazard1(hazard1), .hazard2(hazard2),
    .commit_count(commit_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_cnt;
  logic [AW-1:0] last_addr;

  typedef struct {
    bit            sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            exp_we;
    bit            exp_hz;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_addr  = '0;   req1_addr  = '0;
    req0_data  = '0;   req1_data  = '0;
    readReg1   = '0;   readReg2   = '0;
    @(negedge clock);
    @(negedge clock);
    reset   = 1'b1;
    exp_cnt = '0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[6];
    int   errs, j, d0, d1;
    bit   acc0, acc1, wrap_seen;
    logic [15:0] prev_cc;
    logic [DW-1:0] exp_d;

    tbl[0] = '{0, 5'd5,  32'hDEADBEEF, 1, 1};
    tbl[1] = '{1, 5'd31, 32'h12345678, 1, 1};
    tbl[2] = '{1, 5'd0,  32'h0000FFFF, 0, 0};
    tbl[3] = '{0, 5'd1,  32'h00000000, 1, 1};
    tbl[4] = '{0, 5'd0,  32'hAAAAAAAA, 0, 0};
    tbl[5] = '{1, 5'd17, 32'hFFFFFFFF, 1, 1};

    reset = 1'b1;
    #2;
    do_reset();
    // Reset state, sampled while reset is still asserted
    reset    = 1'b0;
    readReg1 = 5'd5;
    readReg2 = 5'd9;
    #1;
    check("rst_regWrite",  regWrite, 0);
    check("rst_writeReg",  writeReg, 0);
    check("rst_writeData", writeData, 0);
    check("rst_count",     commit_count, 0);
    check("rst_ready0",    req0_ready, 1);
    check("rst_ready1",    req1_ready, 1);
    check("rst_hazard1",   hazard1, 0);
    check("rst_hazard2",   hazard2, 0);
    do_reset();

    // Single uncontested writes, first one on the first edge after release
    last_addr = '0;
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].sel == 0) begin
        req0_valid = 1'b1; req0_addr = tbl[i].addr; req0_data = tbl[i].data;
      end else begin
        req1_valid = 1'b1; req1_addr = tbl[i].addr; req1_data = tbl[i].data;
      end
      readReg1 = tbl[i].addr;
      check("vec_ready", tbl[i].sel ? req1_ready : req0_ready, 1);
      @(negedge clock);
      req0_valid = 1'b0; req1_valid = 1'b0;
      check("vec_early_regWrite", regWrite, 0);
      check("vec_hazard_buffered", hazard1, tbl[i].exp_hz);
      @(negedge clock);
      check("vec_regWrite", regWrite, tbl[i].exp_we);
      if (tbl[i].exp_we) begin
        exp_cnt++;
        last_addr = tbl[i].addr;
        check("vec_writeReg",  writeReg,  tbl[i].addr);
        check("vec_writeData", writeData, tbl[i].data);
      end
      check("vec_count", commit_count, exp_cnt);
      check("vec_hazard_port", hazard1, tbl[i].exp_hz);
      @(negedge clock);
      check("vec_idle_regWrite", regWrite, 0);
      check("vec_idle_writeReg", writeReg, last_addr);
      check("vec_idle_hazard",   hazard1, 0);
      check("vec_idle_ready0",   req0_ready, 1);
      check("vec_idle_ready1",   req1_ready, 1);
    end

    // Contention 3/4, req0 re-offers 6 so the pointer returns to req0
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hA3;
    req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'hA4;
    @(negedge clock);
    check("cont_ready0", req0_ready, 1);
    check("cont_ready1", req1_ready, 0);
    req0_addr = 5'd6; req0_data = 32'hA6; req1_valid = 1'b0;
    @(negedge clock);
    req0_valid = 1'b0;
    check("cont_c1_we",   regWrite, 1);
    check("cont_c1_reg",  writeReg, 3);
    check("cont_c1_data", writeData, 32'hA3);
    check("cont_c1_ready0", req0_ready, 0);
    @(negedge clock);
    check("cont_c2_we",   regWrite, 1);
    check("cont_c2_reg",  writeReg, 4);
    check("cont_c2_data", writeData, 32'hA4);
    @(negedge clock);
    check("cont_c3_reg",  writeReg, 6);
    check("cont_c3_data", writeData, 32'hA6);
    @(negedge clock);
    check("cont_idle_we", regWrite, 0);
    req0_valid = 1'b1; req0_addr = 5'd8; req0_data = 32'hB8;
    req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'hB9;
    @(negedge clock);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clock);
    check("cont2_first_reg", writeReg, 8);
    @(negedge clock);
    check("cont2_second_reg", writeReg, 9);
    check("cont2_count", commit_count, 5);

    // Same destination from both requesters
    do_reset();
    readReg1 = 5'd7; readReg2 = 5'd8;
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'd1;
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'd2;
    @(negedge clock);
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("same_hz_buf", hazard1, 1);
    check("same_hz2",    hazard2, 0);
    @(negedge clock);
    check("same_first_data", writeData, 1);
    check("same_hz_mid",     hazard1, 1);
    @(negedge clock);
    check("same_final_we",   regWrite, 1);
    check("same_final_reg",  writeReg, 7);
    check("same_final_data", writeData, 2);
    check("same_hz_final",   hazard1, 1);
    @(negedge clock);
    check("same_hz_after",   hazard1, 0);
    check("same_count",      commit_count, 2);

    // Asynchronous reset with both buffers occupied
    do_reset();
    readReg2 = 5'd13;
    req0_valid = 1'b1; req0_addr = 5'd12; req0_data = 32'hC12;
    req1_valid = 1'b1; req1_addr = 5'd13; req1_data = 32'hC13;
    @(negedge clock);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clock);
    #2;
    check("mid_pre_we",  regWrite, 1);
    check("mid_pre_hz2", hazard2, 1);
    reset = 1'b0;
    #1;
    check("mid_we",     regWrite, 0);
    check("mid_count",  commit_count, 0);
    check("mid_reg",    writeReg, 0);
    check("mid_ready0", req0_ready, 1);
    check("mid_ready1", req1_ready, 1);
    check("mid_hz2",    hazard2, 0);
    @(negedge clock);
    reset = 1'b1;
    errs = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (regWrite !== 1'b0) errs++;
    end
    check("mid_no_commit_after", errs, 0);
    check("mid_count_after", commit_count, 0);

    // Both requesters streaming through the commit_count wrap
    do_reset();
    d0 = 0; d1 = 0; j = 0; errs = 0; wrap_seen = 1'b0; prev_cc = '0;
    req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'h0;
    req1_valid = 1'b1; req1_addr = 5'd20; req1_data = 32'h8000_0000;
    acc0 = req0_ready; acc1 = req1_ready;
    for (int c = 1; c <= NSTREAM + 1; c++) begin
      @(negedge clock);
      if (acc0) begin d0++; req0_data = d0; end
      if (acc1) begin d1++; req1_data = 32'h8000_0000 | d1; end
      acc0 = req0_ready; acc1 = req1_ready;
      if (c >= 2) begin
        exp_d = (j % 2 == 0) ? DW'(j / 2) : (32'h8000_0000 | DW'(j / 2));
        if (regWrite !== 1'b1 || writeData !== exp_d ||
            writeReg !== ((j % 2 == 0) ? 5'd10 : 5'd20)) begin
          if (errs < 5)
            $display("FAIL stream_commit %0d: got we=%b reg=%0d data=%h expected data %h",
                     j, regWrite, writeReg, writeData, exp_d);
          errs++;
        end
        j++;
        if (commit_count !== 16'(j)) errs++;
        if (prev_cc == 16'hFFFF && commit_count == 16'h0000) wrap_seen = 1'b1;
        prev_cc = commit_count;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("stream_errors",  errs, 0);
    check("stream_commits", j, NSTREAM);
    check("stream_wrap",    wrap_seen, 1);
    check("stream_count",   commit_count, 16'(NSTREAM));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
